// File: rtl/alert_pkg.sv
// Shared types and constants for the alert handler slice.
package alert_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PENDING   = 2'd1,
        ESCALATED = 2'd2
    } alert_state_t;

    localparam logic [1:0] CODE_HIGH = 2'b01;
    localparam logic [1:0] CODE_LOW  = 2'b10;
    localparam int unsigned TIMER_W  = 8;

endpackage

// File: rtl/alert_handler_if.sv
// Alert inputs, host acknowledge/clear, and the registered alert outputs.
interface alert_handler_if #(parameter int CNT_W = 8) ();

    logic             high_alert;
    logic             low_alert;
    logic             ack;
    logic             cnt_clr;
    logic             irq;
    logic [1:0]       alert_code;
    logic             escalate;
    logic [CNT_W-1:0] high_count;
    logic [CNT_W-1:0] low_count;

    modport master (
        output high_alert, low_alert, ack, cnt_clr,
        input  irq, alert_code, escalate, high_count, low_count
    );

    modport slave (
        input  high_alert, low_alert, ack, cnt_clr,
        output irq, alert_code, escalate, high_count, low_count
    );

endinterface

// File: rtl/alert_edge_det.sv
// 1-bit rising-edge detector; previous-value register clears on reset.
module alert_edge_det (
    input  logic clock,
    input  logic reset,
    input  logic i_alert,
    output logic o_edge
);

    logic r_prev;

    always_ff @(posedge clock) begin
        if (reset) r_prev <= 1'b0;
        else       r_prev <= i_alert;
    end

    assign o_edge = i_alert & ~r_prev;

endmodule

// File: rtl/alert_handler.sv
// Alert handler: edge-triggered alert events raise irq, escalate on ack timeout,
// and feed two saturating event counters.
module alert_handler
    import alert_pkg::*;
#(
    parameter int ESC_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic           clock,
    input  logic           reset,
    alert_handler_if.slave bus
);

    localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(ESC_TIMEOUT - 1);

    logic               w_high_ev;
    logic               w_low_ev;
    logic [1:0]         w_ev;
    alert_state_t       r_state;
    alert_state_t       w_state_nxt;
    logic               r_irq,   w_irq_nxt;
    logic [1:0]         r_code,  w_code_nxt;
    logic               r_esc,   w_esc_nxt;
    logic [TIMER_W-1:0] r_timer, w_timer_nxt;
    logic [CNT_W-1:0]   r_high_cnt;
    logic [CNT_W-1:0]   r_low_cnt;

    alert_edge_det u_high_edge (
        .clock   (clock),
        .reset   (reset),
        .i_alert (bus.high_alert),
        .o_edge  (w_high_ev)
    );

    alert_edge_det u_low_edge (
        .clock   (clock),
        .reset   (reset),
        .i_alert (bus.low_alert),
        .o_edge  (w_low_ev)
    );

    assign w_ev = (CODE_HIGH & {2{w_high_ev}}) | (CODE_LOW & {2{w_low_ev}});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_irq   <= 1'b0;
            r_code  <= '0;
            r_esc   <= 1'b0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_irq   <= w_irq_nxt;
            r_code  <= w_code_nxt;
            r_esc   <= w_esc_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:      if (w_ev != '0) w_state_nxt = PENDING;
            PENDING: begin
                if (bus.ack)                  w_state_nxt = (w_ev != '0) ? PENDING : IDLE;
                else if (r_timer == TMO_LAST) w_state_nxt = ESCALATED;
            end
            ESCALATED: if (bus.ack) w_state_nxt = (w_ev != '0) ? PENDING : IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // An ack that coincides with a new event restarts the cycle with only the new cause.
    always_comb begin
        w_irq_nxt   = r_irq;
        w_code_nxt  = r_code;
        w_esc_nxt   = r_esc;
        w_timer_nxt = r_timer;
        unique case (r_state)
            IDLE: begin
                if (w_ev != '0) begin
                    w_irq_nxt   = 1'b1;
                    w_code_nxt  = w_ev;
                    w_timer_nxt = '0;
                end
            end
            PENDING, ESCALATED: begin
                if (bus.ack) begin
                    w_irq_nxt   = (w_ev != '0);
                    w_code_nxt  = w_ev;
                    w_esc_nxt   = 1'b0;
                    w_timer_nxt = '0;
                end else begin
                    w_code_nxt = r_code | w_ev;
                    if (r_state == PENDING) begin
                        w_timer_nxt = r_timer + 1'b1;
                        if (r_timer == TMO_LAST) w_esc_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_irq_nxt   = 1'b0;
                w_code_nxt  = '0;
                w_esc_nxt   = 1'b0;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_high_cnt <= '0;
            r_low_cnt  <= '0;
        end else if (bus.cnt_clr) begin
            r_high_cnt <= CNT_W'(w_high_ev);
            r_low_cnt  <= CNT_W'(w_low_ev);
        end else begin
            if (w_high_ev && (r_high_cnt != '1)) r_high_cnt <= r_high_cnt + 1'b1;
            if (w_low_ev  && (r_low_cnt  != '1)) r_low_cnt  <= r_low_cnt + 1'b1;
        end
    end

    assign bus.irq        = r_irq;
    assign bus.alert_code = r_code;
    assign bus.escalate   = r_esc;
    assign bus.high_count = r_high_cnt;
    assign bus.low_count  = r_low_cnt;

endmodule

// File: tb/tb_alert_handler.sv
// Scoreboard bench: driver queues expected outputs by cycle, monitor checks them at negedge.
module tb_alert_handler;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic high  = 1'b0;
    logic low   = 1'b0;
    logic ack   = 1'b0;
    logic clr   = 1'b0;

    always #5 clock = ~clock;

    alert_handler_if #(.CNT_W(8)) bus_main ();
    alert_handler_if #(.CNT_W(2)) bus_small ();

    assign bus_main.high_alert  = high;
    assign bus_main.low_alert   = low;
    assign bus_main.ack         = ack;
    assign bus_main.cnt_clr     = clr;
    assign bus_small.high_alert = high;
    assign bus_small.low_alert  = low;
    assign bus_small.ack        = ack;
    assign bus_small.cnt_clr    = clr;

    alert_handler #(.ESC_TIMEOUT(16), .CNT_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_main)
    );

    alert_handler #(.ESC_TIMEOUT(16), .CNT_W(2)) dut_small (
        .clock (clock),
        .reset (reset),
        .bus   (bus_small)
    );

    typedef struct {
        int         cyc;
        int         kind;   // 0: full main-DUT outputs, 1: narrow-counter DUT high_count
        logic       irq;
        logic [1:0] code;
        logic       esc;
        logic [7:0] hc;
        logic [7:0] lc;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic exp_main(input int d, input logic irq, input logic [1:0] code,
                            input logic esc, input logic [7:0] hc, input logic [7:0] lc,
                            input string name);
        exp_t e;
        e.cyc = cyc + d; e.kind = 0; e.irq = irq; e.code = code; e.esc = esc;
        e.hc = hc; e.lc = lc; e.name = name;
        q.push_back(e);
    endtask

    task automatic exp_small(input int d, input logic [1:0] hc, input string name);
        exp_t e;
        e.cyc = cyc + d; e.kind = 1; e.irq = 1'b0; e.code = '0; e.esc = 1'b0;
        e.hc = {6'd0, hc}; e.lc = '0; e.name = name;
        q.push_back(e);
    endtask

    always @(negedge clock) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_tests++;
            if (e.kind == 0) begin
                if (bus_main.irq !== e.irq || bus_main.alert_code !== e.code ||
                    bus_main.escalate !== e.esc || bus_main.high_count !== e.hc ||
                    bus_main.low_count !== e.lc) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got irq=%b code=%b esc=%b hc=%0d lc=%0d, want irq=%b code=%b esc=%b hc=%0d lc=%0d",
                             e.name, cyc, bus_main.irq, bus_main.alert_code, bus_main.escalate,
                             bus_main.high_count, bus_main.low_count,
                             e.irq, e.code, e.esc, e.hc, e.lc);
                end
            end else begin
                if ({6'd0, bus_small.high_count} !== e.hc) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got high_count=%0d, want %0d",
                             e.name, cyc, bus_small.high_count, e.hc);
                end
            end
        end
    end

    initial begin
        // Reset and idle state
        reset = 1'b1;
        step(); step();
        exp_main(0, 0, 2'b00, 0, 0, 0, "reset_state");
        step();
        reset = 1'b0;
        step();

        // Single held high level -> one event
        high = 1'b1;
        exp_main(1, 1, 2'b01, 0, 1, 0, "t1_irq");
        repeat (10) step();
        exp_main(0, 1, 2'b01, 0, 1, 0, "t1_hold");
        ack = 1'b1;
        exp_main(1, 0, 2'b00, 0, 1, 0, "t1_ack");
        step();
        ack = 1'b0; high = 1'b0;
        step();

        // Simultaneous high+low edges after a counter clear
        clr = 1'b1;
        exp_main(1, 0, 2'b00, 0, 0, 0, "t2_clr");
        step();
        clr = 1'b0; high = 1'b1; low = 1'b1;
        exp_main(1, 1, 2'b11, 0, 1, 1, "t2_both");
        step(); step(); step();
        ack = 1'b1;
        exp_main(1, 0, 2'b00, 0, 1, 1, "t2_ack");
        step();
        ack = 1'b0; high = 1'b0; low = 1'b0;
        step();

        // Ack in IDLE has no effect
        ack = 1'b1;
        exp_main(1, 0, 2'b00, 0, 1, 1, "idle_ack");
        step();
        ack = 1'b0;

        // Escalation exactly 16 cycles after irq rises
        high = 1'b1;
        exp_main(1, 1, 2'b01, 0, 2, 1, "t3_irq");
        exp_main(16, 1, 2'b01, 0, 2, 1, "t3_pre_esc");
        exp_main(17, 1, 2'b01, 1, 2, 1, "t3_esc");
        repeat (17) step();
        ack = 1'b1;
        exp_main(1, 0, 2'b00, 0, 2, 1, "t3_ack");
        step();
        ack = 1'b0; high = 1'b0;
        step();

        // Ack coinciding with a low edge restarts PENDING and the timer
        high = 1'b1;
        exp_main(1, 1, 2'b01, 0, 3, 1, "t5_irq");
        step(); step();
        low = 1'b1; ack = 1'b1;
        exp_main(1, 1, 2'b10, 0, 3, 2, "t5_ack_ev");
        step();
        ack = 1'b0;
        exp_main(15, 1, 2'b10, 0, 3, 2, "t5_pre_esc");
        exp_main(16, 1, 2'b10, 1, 3, 2, "t5_esc");
        repeat (16) step();
        high = 1'b0; low = 1'b0;
        step();
        high = 1'b1;
        exp_main(1, 1, 2'b11, 1, 4, 2, "t5_or_in_esc");
        step();

        // Reset while ESCALATED with high held; one event after release
        reset = 1'b1;
        exp_main(1, 0, 2'b00, 0, 0, 0, "t6_in_reset");
        step();
        step();
        reset = 1'b0;
        exp_main(1, 1, 2'b01, 0, 1, 0, "t6_post_reset");
        step();
        ack = 1'b1;
        exp_main(1, 0, 2'b00, 0, 1, 0, "t6_ack");
        step();
        ack = 1'b0; high = 1'b0;
        step();

        // 2-bit counter saturation and clear-with-event
        clr = 1'b1;
        exp_small(1, 2'd0, "t4_clr");
        step();
        clr = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            high = 1'b1;
            exp_small(1, (i >= 3) ? 2'd3 : 2'(i), $sformatf("t4_edge%0d", i));
            step();
            high = 1'b0;
            step();
        end
        high = 1'b1; clr = 1'b1;
        exp_small(1, 2'd1, "t4_clr_edge");
        step();
        clr = 1'b0; high = 1'b0;

        // Drain: anything left unchecked after a bounded wait is a failure
        for (int i = 0; i < 5 && q.size() > 0; i++) step();
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: never checked, got none, want cycle %0d", e.name, e.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
